// File: rtl/seq_det_pkg.sv
//------------------------------------------------------------------------------
// Module      : seq_det_pkg
// Description : Shared types and constants for the serial pattern detector.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package seq_det_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [1:0] ST_NONE    = 2'b00;
    localparam logic [1:0] ST_TARGET  = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;
    localparam logic [1:0] ST_ABORT   = 2'b11;

    localparam int DEF_PAT_W = 8;
    localparam int DEF_CNT_W = 8;
    localparam int DEF_TMO_W = 16;

endpackage

`default_nettype wire

// File: rtl/seq_det_ctrl_if.sv
//------------------------------------------------------------------------------
// Module      : seq_det_ctrl_if
// Description : Config, serial data and status bundle of the detector controller.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface seq_det_ctrl_if
    import seq_det_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W,
    parameter int CNT_W = DEF_CNT_W,
    parameter int TMO_W = DEF_TMO_W
);

    logic             cfg_valid;
    logic             cfg_ready;
    logic [PAT_W-1:0] cfg_pattern;
    logic [PAT_W-1:0] cfg_mask;
    logic [CNT_W-1:0] cfg_target;
    logic [TMO_W-1:0] cfg_timeout;
    logic             cfg_overlap;
    logic             abort;
    logic             din_valid;
    logic             din;
    logic             match;
    logic [CNT_W-1:0] match_cnt;
    logic             busy;
    logic             done;
    logic [1:0]       done_status;

    modport master (
        output cfg_valid, cfg_pattern, cfg_mask, cfg_target, cfg_timeout,
               cfg_overlap, abort, din_valid, din,
        input  cfg_ready, match, match_cnt, busy, done, done_status
    );

    modport slave (
        input  cfg_valid, cfg_pattern, cfg_mask, cfg_target, cfg_timeout,
               cfg_overlap, abort, din_valid, din,
        output cfg_ready, match, match_cnt, busy, done, done_status
    );

endinterface

`default_nettype wire

// File: rtl/seq_det_core.sv
//------------------------------------------------------------------------------
// Module      : seq_det_core
// Description : Serial history shift register, fill counter and masked compare.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module seq_det_core
    import seq_det_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din_valid,
    input  logic             din,
    input  logic [PAT_W-1:0] pattern,
    input  logic [PAT_W-1:0] mask,
    input  logic             clear,
    output logic             hit,
    output logic             full_next
);

    localparam int FILL_W = $clog2(PAT_W + 1);

    // Only the newest PAT_W-1 bits need storing; the incoming bit completes the window.
    logic [PAT_W-2:0]  hist_q;
    logic [PAT_W-2:0]  hist_d;
    logic [PAT_W-1:0]  hist_shift;
    logic [FILL_W-1:0] fill_q;
    logic [FILL_W-1:0] fill_d;
    logic [FILL_W-1:0] fill_shift;

    always_comb begin
        hist_shift = {hist_q, din};
        fill_shift = (fill_q == FILL_W'(PAT_W)) ? fill_q : fill_q + FILL_W'(1);
        hit        = din_valid && (fill_shift == FILL_W'(PAT_W))
                     && (((hist_shift ^ pattern) & mask) == '0);

        hist_d = hist_q;
        fill_d = fill_q;
        if (clear) begin
            hist_d = '0;
            fill_d = '0;
        end else if (din_valid) begin
            hist_d = hist_shift[PAT_W-2:0];
            fill_d = fill_shift;
        end
        full_next = (fill_d == FILL_W'(PAT_W));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/seq_det_ctrl.sv
//------------------------------------------------------------------------------
// Module      : seq_det_ctrl
// Description : Run controller: config handshake, match counting, run end status.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module seq_det_ctrl
    import seq_det_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W,
    parameter int CNT_W = DEF_CNT_W,
    parameter int TMO_W = DEF_TMO_W
) (
    input  logic          clk,
    input  logic          rst,
    seq_det_ctrl_if.slave bus
);

    state_t           state_q, state_d;
    logic [PAT_W-1:0] pattern_q, pattern_d;
    logic [PAT_W-1:0] mask_q, mask_d;
    logic [CNT_W-1:0] target_q, target_d;
    logic [TMO_W-1:0] timeout_q, timeout_d;
    logic             overlap_q, overlap_d;
    logic [TMO_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             match_q, match_d;
    logic [1:0]       status_q, status_d;

    logic             active;
    logic             cfg_ready;
    logic             accept;
    logic             core_valid;
    logic             core_clear;
    logic             hit;
    logic             full_next;

    assign active     = (state_q == FILL) || (state_q == RUN);
    assign cfg_ready  = (state_q == IDLE) || (state_q == DONE);
    assign accept     = bus.cfg_valid && cfg_ready;
    assign core_valid = active && bus.din_valid;
    // Non-overlapping mode restarts the window after every hit; abort discards the hit.
    assign core_clear = accept || (active && hit && !overlap_q && !bus.abort);

    seq_det_core #(
        .PAT_W (PAT_W)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .din_valid (core_valid),
        .din       (bus.din),
        .pattern   (pattern_q),
        .mask      (mask_q),
        .clear     (core_clear),
        .hit       (hit),
        .full_next (full_next)
    );

    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        mask_d    = mask_q;
        target_d  = target_q;
        timeout_d = timeout_q;
        overlap_d = overlap_q;
        timer_d   = timer_q;
        cnt_d     = cnt_q;
        match_d   = 1'b0;
        status_d  = status_q;
        cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    pattern_d = bus.cfg_pattern;
                    mask_d    = bus.cfg_mask;
                    target_d  = bus.cfg_target;
                    timeout_d = bus.cfg_timeout;
                    overlap_d = bus.cfg_overlap;
                    timer_d   = '0;
                    cnt_d     = '0;
                    status_d  = ST_NONE;
                    state_d   = FILL;
                end
            end
            default: begin
                timer_d = timer_q + TMO_W'(1);
                if (bus.abort) begin
                    state_d  = DONE;
                    status_d = ST_ABORT;
                end else begin
                    state_d = full_next ? RUN : FILL;
                    if (hit) begin
                        match_d = 1'b1;
                        cnt_d   = cnt_inc;
                    end
                    // Target outranks timeout when both land on the same edge.
                    if (hit && (target_q != '0) && (cnt_inc == target_q)) begin
                        state_d  = DONE;
                        status_d = ST_TARGET;
                    end else if ((timeout_q != '0) && (timer_q == timeout_q - TMO_W'(1))) begin
                        state_d  = DONE;
                        status_d = ST_TIMEOUT;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pattern_q <= '0;
            mask_q    <= '0;
            target_q  <= '0;
            timeout_q <= '0;
            overlap_q <= 1'b0;
            timer_q   <= '0;
            cnt_q     <= '0;
            match_q   <= 1'b0;
            status_q  <= ST_NONE;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            mask_q    <= mask_d;
            target_q  <= target_d;
            timeout_q <= timeout_d;
            overlap_q <= overlap_d;
            timer_q   <= timer_d;
            cnt_q     <= cnt_d;
            match_q   <= match_d;
            status_q  <= status_d;
        end
    end

    assign bus.cfg_ready   = cfg_ready;
    assign bus.match       = match_q;
    assign bus.match_cnt   = cnt_q;
    assign bus.busy        = active;
    assign bus.done        = (state_q == DONE);
    assign bus.done_status = status_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_det_ctrl.sv
//------------------------------------------------------------------------------
// Module      : tb_seq_det_ctrl
// Description : Directed and random bench for seq_det_ctrl with a queue-based model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_seq_det_ctrl;
    import seq_det_pkg::*;

    localparam int PAT_W = 8;
    localparam int CNT_W = 8;
    localparam int TMO_W = 16;

    logic clk = 1'b0;
    logic rst;

    seq_det_ctrl_if #(.PAT_W(PAT_W), .CNT_W(CNT_W), .TMO_W(TMO_W)) bus ();

    seq_det_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W), .TMO_W(TMO_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: a window of recent bits and plain counters.
    bit m_running, m_done, m_match;
    int m_cnt, m_status, m_cycles;
    bit m_win[$];
    int c_pat, c_mask, c_target, c_timeout;
    bit c_ovl;

    function automatic void model_reset();
        m_running = 0; m_done = 0; m_match = 0;
        m_cnt = 0; m_status = 0; m_cycles = 0;
        m_win.delete();
    endfunction

    function automatic void model_step();
        bit hit;
        int p;
        hit = 0;
        m_match = 0;
        if (!m_running) begin
            if (bus.cfg_valid) begin
                c_pat = int'(bus.cfg_pattern); c_mask = int'(bus.cfg_mask);
                c_target = int'(bus.cfg_target); c_timeout = int'(bus.cfg_timeout);
                c_ovl = bus.cfg_overlap;
                m_running = 1; m_done = 0; m_win.delete();
                m_cycles = 0; m_cnt = 0; m_status = 0;
            end
        end else if (bus.abort) begin
            m_running = 0; m_done = 1; m_status = 3;
        end else begin
            if (bus.din_valid) begin
                m_win.push_back(bus.din);
                if (m_win.size() > PAT_W) void'(m_win.pop_front());
                if (m_win.size() == PAT_W) begin
                    p = 0;
                    foreach (m_win[i]) p = p * 2 + int'(m_win[i]);
                    hit = (((p ^ c_pat) & c_mask) == 0);
                end
            end
            if (hit) begin
                m_match = 1;
                if (m_cnt < 255) m_cnt++;
                if (!c_ovl) m_win.delete();
            end
            m_cycles++;
            if (hit && c_target != 0 && m_cnt == c_target) begin
                m_running = 0; m_done = 1; m_status = 1;
            end else if (c_timeout != 0 && m_cycles == c_timeout) begin
                m_running = 0; m_done = 1; m_status = 2;
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("cfg_ready",   32'(bus.cfg_ready),   32'(!m_running));
        chk("busy",        32'(bus.busy),        32'(m_running));
        chk("done",        32'(bus.done),        32'(m_done));
        chk("done_status", 32'(bus.done_status), 32'(m_status));
        chk("match",       32'(bus.match),       32'(m_match));
        chk("match_cnt",   32'(bus.match_cnt),   32'(m_cnt));
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset(); else model_step();
        #1;
        check_all();
    endtask

    task automatic cfg(input logic [7:0] pat, input logic [7:0] msk, input int tgt,
                       input int tmo, input logic ovl);
        bus.cfg_pattern = pat; bus.cfg_mask = msk;
        bus.cfg_target = CNT_W'(tgt); bus.cfg_timeout = TMO_W'(tmo);
        bus.cfg_overlap = ovl; bus.cfg_valid = 1'b1;
        tick();
        bus.cfg_valid = 1'b0;
    endtask

    task automatic send_bits(input logic [15:0] bits, input int n, output int pulses);
        logic [15:0] b;
        b = bits;
        pulses = 0;
        for (int i = n - 1; i >= 0; i--) begin
            bus.din_valid = 1'b1; bus.din = b[i];
            tick();
            if (bus.match === 1'b1) pulses++;
        end
        bus.din_valid = 1'b0; bus.din = 1'b0;
    endtask

    task automatic do_abort();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
    endtask

    initial begin
        int pulses;
        int n;
        rst = 1'b1;
        bus.cfg_valid = 0; bus.cfg_pattern = 0; bus.cfg_mask = 0; bus.cfg_target = 0;
        bus.cfg_timeout = 0; bus.cfg_overlap = 0; bus.abort = 0; bus.din_valid = 0; bus.din = 0;
        model_reset();
        #1;
        check_all();
        tick(); tick();
        rst = 1'b0;
        tick();

        // Don't-care bits in the mask let 0111_0110 match 0110_0110.
        cfg(8'b0110_0110, 8'b1110_0111, 1, 0, 1'b0);
        send_bits(16'b0111_0110, 8, pulses);
        chk("t1_match", 32'(bus.match), 32'd1);
        chk("t1_status", 32'(bus.done_status), 32'd1);
        chk("t1_cnt", 32'(bus.match_cnt), 32'd1);
        tick();

        cfg(8'h05, 8'h0F, 0, 0, 1'b1);
        send_bits(16'b00_0000_0101_01, 10, pulses);
        chk("t2_ovl1_pulses", 32'(pulses), 32'd2);
        do_abort();
        cfg(8'h05, 8'h0F, 0, 0, 1'b0);
        send_bits(16'b00_0000_0101_01, 10, pulses);
        chk("t2_ovl0_pulses", 32'(pulses), 32'd1);
        do_abort();

        cfg(8'hFF, 8'hFF, 0, 20, 1'b0);
        n = 0;
        bus.din_valid = 1'b1; bus.din = 1'b0;
        while (bus.done !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        bus.din_valid = 1'b0;
        chk("t3_tmo_len", 32'(n), 32'd20);
        chk("t3_status", 32'(bus.done_status), 32'd2);
        chk("t3_cnt", 32'(bus.match_cnt), 32'd0);

        // Hits on bits 8..10; the third lands on the timeout edge.
        cfg(8'h00, 8'h00, 3, 10, 1'b1);
        send_bits(16'h3FF, 10, pulses);
        chk("t4_status", 32'(bus.done_status), 32'd1);
        chk("t4_cnt", 32'(bus.match_cnt), 32'd3);

        cfg(8'hA5, 8'hFF, 0, 0, 1'b0);
        send_bits(16'b10100, 5, pulses);
        do_abort();
        chk("t5_status", 32'(bus.done_status), 32'd3);
        chk("t5_busy", 32'(bus.busy), 32'd0);
        cfg(8'h00, 8'h00, 0, 0, 1'b1);
        chk("t5_restart_busy", 32'(bus.busy), 32'd1);
        send_bits(16'h1FF, 9, pulses);
        chk("t6_cnt_before_rst", 32'(bus.match_cnt), 32'd2);
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("t6_async_ready", 32'(bus.cfg_ready), 32'd1);
        tick();
        rst = 1'b0;
        send_bits(16'hFFFF, 12, pulses);
        chk("t6_no_match_after_rst", 32'(pulses), 32'd0);

        for (int i = 0; i < 1500; i++) begin
            bus.cfg_valid   = ($urandom_range(0, 15) == 0);
            bus.cfg_pattern = PAT_W'($urandom);
            bus.cfg_mask    = PAT_W'($urandom & $urandom & $urandom);
            bus.cfg_target  = CNT_W'($urandom_range(0, 3));
            bus.cfg_timeout = ($urandom_range(0, 2) == 0) ? '0 : TMO_W'($urandom_range(1, 60));
            bus.cfg_overlap = 1'($urandom);
            bus.abort       = ($urandom_range(0, 49) == 0);
            bus.din_valid   = ($urandom_range(0, 3) != 0);
            bus.din         = 1'($urandom);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/seq_det_ctrl.md
Name: seq_det_ctrl

Overview:
Run controller for the serial pattern detector. It accepts a run configuration through a valid/ready handshake: an 8-bit pattern with a care mask (don't-care bits allowed), a match target, a timeout and an overlap mode. It then arms the detector on the serial bit stream, counts matches, and ends the run on target reached, timeout or abort, reporting a status. It sits between the config/CSR side and the serial input line.

Parameters:
PAT_W, 8, pattern/history length in bits
CNT_W, 8, match counter and target width
TMO_W, 16, timeout counter width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
cfg_valid  in  1  config offer
cfg_ready  out  1  high in IDLE and DONE
cfg_pattern  in  PAT_W  MSB = first bit received
cfg_mask  in  PAT_W  1 = bit compared, 0 = don't care
cfg_target  in  CNT_W  matches to end run; 0 = unlimited
cfg_timeout  in  TMO_W  run length in cycles; 0 = disabled
cfg_overlap  in  1  1 = overlapping matches allowed
abort  in  1  terminate current run
din_valid  in  1  din sampled this cycle
din  in  1  serial data bit
match  out  1  one-cycle pulse per detected match
match_cnt  out  CNT_W  matches in current/last run, saturating
busy  out  1  high in FILL or RUN
done  out  1  high while in DONE
done_status  out  2  00 none, 01 target, 10 timeout, 11 aborted

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high (ports clk, rst).
- Reset state: IDLE. match=0, match_cnt=0, busy=0, done=0, done_status=00. cfg_ready=1 (decoded from state). History, fill count and timer are cleared.
- IDLE or DONE, when cfg_valid && cfg_ready: latch all cfg_* fields. Clear history, fill count, match_cnt, timer and done_status. Go to FILL. Config is ignored in FILL and RUN (cfg_ready=0).
- History update: on din_valid, hist_next = {hist[PAT_W-2:0], din}. The fill count increments, saturating at PAT_W.
- FILL: compare is disabled until the fill count reaches PAT_W, then go to RUN. The transition happens in the cycle after the PAT_W-th bit.
- Compare condition: ((hist_next ^ pattern) & mask) == 0. It is evaluated only on a din_valid beat whose fill count after the shift is PAT_W. The beat that completes the 8th bit in FILL is checked.
- On a compare hit:
  - match is registered high in the next cycle for exactly one cycle.
  - match_cnt increments the same edge, saturating at all-ones.
  - If overlap=0, the fill count and history clear and the state returns to FILL. If overlap=1, history is retained.
- Timer: counts every cycle in FILL/RUN, from 0 after config. When timeout≠0 and timer reaches timeout-1, go to DONE with status 10 on the next edge. The run therefore lasts exactly timeout cycles.
- Target: when target≠0 and the incremented match_cnt equals target, go to DONE with status 01 on the same edge as the match pulse is launched.
- Priority on the same edge: abort > target > timeout. A match on the timeout edge is still counted and pulsed, and status is 01 if that match reaches the target.
- abort: in FILL/RUN, go to DONE with status 11 next edge; a compare hit in that cycle is discarded. In IDLE/DONE, abort has no effect.
- DONE: done=1, busy=0; match_cnt and done_status hold until a new config is accepted. din is ignored outside FILL/RUN.
- Asserting rst mid-run returns immediately to the reset state; no done is produced.

Decomposition:
- Package seq_det_pkg: state enum {IDLE, FILL, RUN, DONE}, status constants ST_NONE/ST_TARGET/ST_TIMEOUT/ST_ABORT, default PAT_W.
- Sub-module seq_det_core: history shift register, fill counter and masked comparator. Inputs: din_valid, din, pattern, mask, clear. Output: hit (combinational).
- The controller holds the FSM, config registers, timer, counter and output registers.

Test Plan:
- Pattern 8'b0110_0110, mask 8'b1110_0111, target=1, timeout=0. Stream 0,1,1,1,0,1,1,0 (one bit per cycle) -> match pulse one cycle after the last bit, done_status=01, match_cnt=1.
- Pattern 8'h05, mask 8'h0F, overlap=1, target=0. Stream 0000_0101 then 0,1 -> two match pulses, after bits 8 and 10. Same run with overlap=0 -> only one match.
- Pattern 8'hFF, mask 8'hFF, timeout=20, din constant 0 -> DONE exactly 20 cycles after config accept, status 10, match_cnt=0, no match pulse.
- Target=3 hit on the same cycle as timeout expiry -> status 01, match_cnt=3.
- Abort asserted 5 cycles into FILL -> DONE next edge, status 11, busy=0. A new cfg_valid in DONE is accepted and restarts the run with match_cnt cleared.
- Reset asserted mid-RUN with match_cnt=2 -> all outputs 0 asynchronously and cfg_ready=1. din_valid pulses after reset produce no match until a config is accepted.
